// File: rtl/frame_deser.sv
// Serial-to-parallel frame receiver with HUNT/SYNC/LOCKED acquisition and a valid/ready output.
// Define DESER_ERRCNT_EN to build the saturating error counter; otherwise err_count is tied to 0.
module frame_deser #(
    parameter int FRAME_BITS  = 256,
    parameter int LOCK_FRAMES = 2,
    parameter int UNLOCK_ERRS = 3,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  sdata,
    input  logic                  sfs,
    input  logic                  pready,
    input  logic                  err_clr,
    output logic                  pvalid,
    output logic [FRAME_BITS-1:0] pdata,
    output logic                  locked,
    output logic                  frame_err,
    output logic                  overrun,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [1:0]            state_dbg
);

    localparam int BW   = $clog2(FRAME_BITS + 1);
    localparam int GW   = $clog2(LOCK_FRAMES + 1);
    localparam int BADW = $clog2(UNLOCK_ERRS + 1);

    localparam logic [BW-1:0]   FULL      = BW'(FRAME_BITS);
    localparam logic [GW-1:0]   GOOD_LAST = GW'(LOCK_FRAMES - 1);
    localparam logic [BADW-1:0] BAD_LAST  = BADW'(UNLOCK_ERRS - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [BW-1:0]         r_bitcnt;
    logic                  r_overlong;
    logic [GW-1:0]         r_good_cnt;
    logic [BADW-1:0]       r_bad_cnt;
    logic                  r_locked;
    logic                  r_pvalid;
    logic [FRAME_BITS-1:0] r_pdata;
    logic                  r_frame_err;
    logic                  r_overrun;

    logic w_in_frame;
    logic w_full;
    logic w_close;
    logic w_good;
    logic w_short;
    logic w_long;
    logic w_err;
    logic w_deliver;

    // An overlong frame is already reported, so its closing sfs is neither good nor short.
    assign w_in_frame = (r_state != HUNT);
    assign w_full     = (r_bitcnt == FULL);
    assign w_close    = sfs && w_in_frame;
    assign w_good     = w_close && w_full && !r_overlong;
    assign w_short    = w_close && !w_full;
    assign w_long     = !sfs && w_full && w_in_frame && !r_overlong;
    assign w_err      = w_short || w_long;
    assign w_deliver  = w_good && (r_state == LOCKED);

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_overlong <= 1'b0;
        end else begin
            if (sfs) begin
                r_shift    <= {{(FRAME_BITS-1){1'b0}}, sdata};
                r_bitcnt   <= BW'(1);
                r_overlong <= 1'b0;
            end else if (!w_full) begin
                r_shift  <= {r_shift[FRAME_BITS-2:0], sdata};
                r_bitcnt <= r_bitcnt + BW'(1);
            end
            if (w_long) begin
                r_overlong <= 1'b1;
            end
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state    <= HUNT;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            r_locked   <= 1'b0;
        end else begin
            case (r_state)
                HUNT: begin
                    if (sfs) begin
                        r_state    <= SYNC;
                        r_good_cnt <= '0;
                    end
                end
                SYNC: begin
                    if (w_good) begin
                        if (r_good_cnt == GOOD_LAST) begin
                            r_state    <= LOCKED;
                            r_locked   <= 1'b1;
                            r_good_cnt <= '0;
                            r_bad_cnt  <= '0;
                        end else begin
                            r_good_cnt <= r_good_cnt + GW'(1);
                        end
                    end else if (w_err) begin
                        r_good_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (w_good) begin
                        r_bad_cnt <= '0;
                    end else if (w_err) begin
                        if (r_bad_cnt == BAD_LAST) begin
                            r_state    <= SYNC;
                            r_locked   <= 1'b0;
                            r_good_cnt <= '0;
                            r_bad_cnt  <= '0;
                        end else begin
                            r_bad_cnt <= r_bad_cnt + BADW'(1);
                        end
                    end
                end
                default: begin
                    r_state  <= HUNT;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    // Handshake: a frame transfers on a clock edge where pvalid and pready are both high;
    // pdata holds still while pvalid is high and pready is low, and is kept after transfer.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_pvalid    <= 1'b0;
            r_pdata     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            r_overrun   <= 1'b0;
            if (w_deliver) begin
                if (!r_pvalid || pready) begin
                    r_pdata  <= r_shift;
                    r_pvalid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_pvalid && pready) begin
                r_pvalid <= 1'b0;
            end
        end
    end

`ifdef DESER_ERRCNT_EN
    logic [ERR_CNT_W-1:0] r_err_count;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= '0;
        end else if (w_err && (r_err_count != {ERR_CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign err_count        = '0;
`endif

    assign pvalid    = r_pvalid;
    assign pdata     = r_pdata;
    assign locked    = r_locked;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_frame_deser.sv
// Self-checking bench for frame_deser with FRAME_BITS=8: acquisition, errors, backpressure, reset.
module tb_frame_deser;

    localparam int FB = 8;
    localparam int EW = 16;
`ifdef DESER_ERRCNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif
    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic          sclk;
    logic          rst;
    logic          sdata;
    logic          sfs;
    logic          pready;
    logic          err_clr;
    logic          pvalid;
    logic [FB-1:0] pdata;
    logic          locked;
    logic          frame_err;
    logic          overrun;
    logic [EW-1:0] err_count;
    logic [1:0]    state_dbg;

    logic [FB-1:0] exp_q[$];
    int            n_checks;
    int            n_errs;
    int            n_ferr;
    int            n_ovr;
    int            err_m;
    int            ferr0;
    logic [15:0]   rnd;

    frame_deser #(
        .FRAME_BITS (FB),
        .LOCK_FRAMES(2),
        .UNLOCK_ERRS(3),
        .ERR_CNT_W  (EW)
    ) dut (
        .sclk     (sclk),
        .rst      (rst),
        .sdata    (sdata),
        .sfs      (sfs),
        .pready   (pready),
        .err_clr  (err_clr),
        .pvalid   (pvalid),
        .pdata    (pdata),
        .locked   (locked),
        .frame_err(frame_err),
        .overrun  (overrun),
        .err_count(err_count),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic drive_bit(input logic fs, input logic d);
        sfs   = fs;
        sdata = d;
        @(posedge sclk);
        #1;
    endtask

    task automatic send_head(input logic [15:0] data, input int nbits);
        drive_bit(1'b1, data[nbits-1]);
    endtask

    task automatic send_rest(input logic [15:0] data, input int nbits, input int from);
        for (int i = from; i < nbits; i++) begin
            drive_bit(1'b0, data[nbits-1-i]);
        end
    endtask

    task automatic send_frame(input logic [15:0] data, input int nbits);
        send_head(data, nbits);
        send_rest(data, nbits, 1);
    endtask

    // scoreboard monitor: a transfer happens at the next rising edge
    always @(negedge sclk) begin
        if (!rst) begin
            if (pvalid && pready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_frame", 32'(pdata), 32'hFFFF_FFFF);
                end else begin
                    check_eq("pdata_sb", 32'(pdata), 32'(exp_q.pop_front()));
                end
            end
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
        end
    end

    initial begin
        n_checks = 0;
        n_errs   = 0;
        n_ferr   = 0;
        n_ovr    = 0;
        err_m    = 0;
        rst      = 1'b1;
        sdata    = 1'b0;
        sfs      = 1'b0;
        pready   = 1'b0;
        err_clr  = 1'b0;
        #1;
        check_eq("rst_pvalid", 32'(pvalid), 32'd0);
        check_eq("rst_pdata", 32'(pdata), 32'd0);
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'(ST_HUNT));
        @(posedge sclk);
        #1;
        rst = 1'b0;

        // acquisition: two good frames in SYNC lock, first delivered frame is 0xF0
        pready = 1'b1;
        send_head(16'hA5, 8);
        check_eq("hunt_to_sync", 32'(state_dbg), 32'(ST_SYNC));
        send_rest(16'hA5, 8, 1);
        send_frame(16'h3C, 8);
        check_eq("not_locked_yet", 32'(locked), 32'd0);
        send_head(16'hF0, 8);
        check_eq("locked_rise", 32'(locked), 32'd1);
        check_eq("state_locked", 32'(state_dbg), 32'(ST_LOCKED));
        check_eq("no_pvalid_in_sync", 32'(pvalid), 32'd0);
        send_rest(16'hF0, 8, 1);
        exp_q.push_back(8'hF0);
        send_head(16'h81, 8);
        check_eq("first_pvalid", 32'(pvalid), 32'd1);
        check_eq("first_pdata", 32'(pdata), 32'hF0);
        drive_bit(1'b0, 1'b0);
        check_eq("pvalid_one_cycle", 32'(pvalid), 32'd0);
        send_rest(16'h81, 8, 2);
        check_eq("no_err_acq", 32'(n_ferr), 32'd0);

        // short frame in LOCKED
        exp_q.push_back(8'h81);
        rnd = 16'($urandom_range(0, 31));
        send_frame(rnd, 5);
        send_head(16'h3C, 8);
        err_m += CNT_EN;
        check_eq("short_err", 32'(frame_err), 32'd1);
        check_eq("short_err_count", 32'(err_count), 32'(err_m));
        check_eq("short_locked", 32'(locked), 32'd1);
        check_eq("short_no_pvalid", 32'(pvalid), 32'd0);
        send_rest(16'h3C, 8, 1);

        // overlong frame in LOCKED: single error at bitcnt==FRAME_BITS with sfs low
        exp_q.push_back(8'h3C);
        ferr0 = n_ferr;
        rnd = 16'($urandom_range(0, 4095));
        send_head(rnd, 12);
        check_eq("long_head_no_err", 32'(frame_err), 32'd0);
        for (int i = 1; i < 12; i++) begin
            drive_bit(1'b0, rnd[11-i]);
            check_eq("long_err_pos", 32'(frame_err), 32'(i == 8));
        end
        err_m += CNT_EN;
        send_head(16'hC3, 8);
        check_eq("long_close_no_err", 32'(frame_err), 32'd0);
        check_eq("long_err_once", 32'(n_ferr - ferr0), 32'd1);
        check_eq("long_err_count", 32'(err_count), 32'(err_m));
        check_eq("long_locked", 32'(locked), 32'd1);
        send_rest(16'hC3, 8, 1);

        // three consecutive short frames unlock, two good frames re-lock
        exp_q.push_back(8'hC3);
        for (int k = 0; k < 3; k++) begin
            rnd = 16'($urandom_range(0, 15));
            send_head(rnd, 4);
            check_eq("still_locked", 32'(locked), 32'd1);
            send_rest(rnd, 4, 1);
        end
        send_head(16'h11, 8);
        err_m += 3 * CNT_EN;
        check_eq("unlock_fall", 32'(locked), 32'd0);
        check_eq("unlock_state", 32'(state_dbg), 32'(ST_SYNC));
        check_eq("unlock_err_count", 32'(err_count), 32'(err_m));
        send_rest(16'h11, 8, 1);
        send_head(16'h22, 8);
        check_eq("relock_pending", 32'(locked), 32'd0);
        send_rest(16'h22, 8, 1);
        send_head(16'h77, 8);
        check_eq("relock", 32'(locked), 32'd1);
        send_rest(16'h77, 8, 1);

        // backpressure: second frame overruns, pdata keeps the first
        pready = 1'b0;
        exp_q.push_back(8'h77);
        send_head(16'h9A, 8);
        check_eq("bp_pvalid", 32'(pvalid), 32'd1);
        check_eq("bp_pdata", 32'(pdata), 32'h77);
        send_rest(16'h9A, 8, 1);
        send_head(16'hB4, 8);
        check_eq("overrun_pulse", 32'(overrun), 32'd1);
        check_eq("overrun_pvalid", 32'(pvalid), 32'd1);
        check_eq("overrun_pdata", 32'(pdata), 32'h77);
        drive_bit(1'b0, 1'b0);
        check_eq("overrun_one_cycle", 32'(overrun), 32'd0);
        check_eq("bp_pdata_stable", 32'(pdata), 32'h77);
        pready = 1'b1;
        drive_bit(1'b0, 1'b1);
        check_eq("bp_release_pvalid", 32'(pvalid), 32'd0);
        check_eq("bp_pdata_kept", 32'(pdata), 32'h77);
        check_eq("overrun_count", 32'(n_ovr), 32'd1);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        // reset mid-frame
        drive_bit(1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_pvalid", 32'(pvalid), 32'd0);
        check_eq("mid_rst_pdata", 32'(pdata), 32'd0);
        check_eq("mid_rst_locked", 32'(locked), 32'd0);
        check_eq("mid_rst_frame_err", 32'(frame_err), 32'd0);
        check_eq("mid_rst_overrun", 32'(overrun), 32'd0);
        check_eq("mid_rst_err_count", 32'(err_count), 32'd0);
        check_eq("mid_rst_state", 32'(state_dbg), 32'(ST_HUNT));
        @(posedge sclk);
        #1;
        rst   = 1'b0;
        err_m = 0;
        ferr0 = n_ferr;
        send_frame(16'h5A, 8);
        check_eq("post_rst_pvalid", 32'(pvalid), 32'd0);
        check_eq("post_rst_no_err", 32'(n_ferr - ferr0), 32'd0);
        check_eq("post_rst_state", 32'(state_dbg), 32'(ST_SYNC));

        // err_clr coincident with an error
        drive_bit(1'b0, 1'b0);
        err_m += CNT_EN;
        check_eq("sync_long_err", 32'(frame_err), 32'd1);
        check_eq("sync_err_count", 32'(err_count), 32'(err_m));
        send_head(16'h5, 3);
        check_eq("overlong_close_no_err", 32'(frame_err), 32'd0);
        send_rest(16'h5, 3, 1);
        err_clr = 1'b1;
        send_head(16'h66, 8);
        err_clr = 1'b0;
        check_eq("clr_err_pulse", 32'(frame_err), 32'd1);
        check_eq("clr_wins", 32'(err_count), 32'd0);
        send_rest(16'h66, 8, 1);
        check_eq("final_err_count", 32'(err_count), 32'd0);
        check_eq("final_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/frame_deser.md
Name: frame_deser

Overview:
- Parametrised successor to the fixed 256-bit testbench serial rectifier.
- Deserialises an MSB-first serial stream, framed by `sfs`, into FRAME_BITS-wide words.
- Checks frame lengths and runs a HUNT/SYNC/LOCKED acquisition FSM with lock hysteresis.
- Delivers frames over a valid/ready interface, with overrun and error reporting, for use as a bench monitor or RTL receive front end.

Parameters:
- FRAME_BITS, 256: bits per frame (>=4).
- LOCK_FRAMES, 2: consecutive good frames needed in SYNC to enter LOCKED (>=1).
- UNLOCK_ERRS, 3: consecutive bad frames in LOCKED that drop back to SYNC (>=1).
- ERR_CNT_W, 16: width of the error counter.

Ports:
- sclk  in  1  serial bit clock; every rising edge samples one bit.
- rst  in  1  asynchronous, active-high reset.
- sdata  in  1  serial data bit.
- sfs  in  1  frame sync; high on the first bit of each frame.
- pready  in  1  downstream accepts pdata.
- err_clr  in  1  synchronous clear of err_count.
- pvalid  out  1  pdata holds an undelivered frame.
- pdata  out  FRAME_BITS  frame word; first bit received lands in MSB.
- locked  out  1  FSM is in LOCKED.
- frame_err  out  1  one-cycle pulse per detected frame error.
- overrun  out  1  one-cycle pulse when a good frame is dropped because the holding register is full.
- err_count  out  ERR_CNT_W  saturating count of frame errors.

Behaviour:
- Reset (async, rst=1): state=HUNT. shift register, bitcnt, good/bad counters, pvalid, pdata, locked, frame_err, overrun and err_count all go to 0. Reset mid-frame discards all partial data.
- bitcnt (width ceil(log2(FRAME_BITS+1))):
  - sfs=1: bitcnt<=1, shift<={0..,sdata}.
  - Otherwise, if bitcnt<FRAME_BITS: bitcnt++, shift<={shift,sdata}.
- Frame close: an sfs while state!=HUNT closes the previous frame.
  - Good if bitcnt==FRAME_BITS at that edge.
  - Short if bitcnt<FRAME_BITS.
- Long error: bitcnt==FRAME_BITS and sfs=0 while in SYNC or LOCKED.
  - Error fires at that edge. Shifting freezes and an overlong flag is set.
  - The next sfs starts a new frame without a second error, and clears the flag.
- Each error (short or long): frame_err pulses 1 cycle; err_count saturates at all-ones.
- FSM:
  - HUNT: sfs -> SYNC, good_cnt=0. No errors are reported in HUNT.
  - SYNC:
    - Good close -> good_cnt++. Go to LOCKED when good_cnt reaches LOCK_FRAMES.
    - Error -> good_cnt=0, stay in SYNC.
    - Frames are never delivered in SYNC.
  - LOCKED:
    - Good close -> deliver the frame, bad_cnt=0.
    - Error -> bad_cnt++, frame discarded. When bad_cnt reaches UNLOCK_ERRS -> SYNC, good_cnt=0, bad_cnt=0.
- locked=1 exactly while state==LOCKED (registered).
- Delivery (LOCKED, good close at edge N):
  - At N+1: pdata=frame, pvalid=1.
  - If pvalid=1 and pready=0 at edge N: the frame is dropped, overrun pulses at N+1, pdata and pvalid are unchanged.
  - If pvalid=1 and pready=1 at edge N: the new frame loads, pvalid stays 1, no overrun.
- Handshake:
  - pvalid&&pready with no new frame -> pvalid<=0. pdata is retained.
  - pdata is stable while pvalid=1 and pready=0.
- err_clr and an error at the same edge: clear wins, err_count=0.

Optional Feature:
- DESER_ERRCNT_EN defined: err_count and err_clr are implemented as above.
- DESER_ERRCNT_EN undefined: there is no counter logic, err_count is tied to 0 and err_clr is ignored.
- frame_err, the FSM and delivery are identical in both builds.

Test Plan:
- FRAME_BITS=8, LOCK_FRAMES=2. Send sfs and frames 0xA5, 0x3C, 0xF0, 0x81, each exactly 8 bits, with pready=1.
  - locked rises 1 cycle after the 3rd sfs.
  - The frame closed by the 4th sfs gives pvalid for 1 cycle with pdata=0xF0.
  - frame_err never pulses.
- In LOCKED, assert sfs after 5 bits.
  - frame_err pulses once and err_count=1. No pvalid for that frame; locked stays 1.
- In LOCKED, hold sfs low for 12 bits.
  - frame_err pulses at the 8th bit only. The next sfs adds no further error.
  - err_count increments by exactly 1.
- UNLOCK_ERRS=3, in LOCKED: three consecutive short frames.
  - locked falls 1 cycle after the 3rd error.
  - Two following good frames re-lock.
- pready=0 with two good frames in LOCKED.
  - pdata keeps the 1st frame and overrun pulses once.
  - Raising pready clears pvalid the next cycle.
- Assert rst mid-frame.
  - All outputs read 0 immediately and the FSM is in HUNT.
  - A full frame after release produces no output and no error.
- err_clr coincident with an error.
  - err_count=0.
  - With DESER_ERRCNT_EN undefined, err_count stays 0 throughout.
